// File: rtl/uart_pkg.sv
// uart_pkg: shared types and helpers for the nvboard UART receive/send path.
// Build option: UART_RX_PARITY_EN adds an even parity bit to the receive frame.
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP,
        BREAK
    } rx_state_t;

    localparam int UART_DATA_W = 8;

    // Clock cycles per oversample tick, truncated, never below 1.
    function automatic int calc_div(input longint clk_freq, input longint baud,
                                    input longint oversample);
        longint d;
        d = clk_freq / (baud * oversample);
        return (d < 1) ? 1 : int'(d);
    endfunction

endpackage

// File: rtl/uart_receiver_if.sv
// uart_receiver_if: serial input plus the received-byte / status bundle.
// master = the receiver, slave = the display/loopback consumer driving the line.
interface uart_receiver_if;
    import uart_pkg::*;

    logic                   rxd;
    logic [UART_DATA_W-1:0] recv_data;
    logic                   recv_valid;
    logic                   frame_err;
    logic                   parity_err;
    logic                   busy;

    modport master (
        input  rxd,
        output recv_data, recv_valid, frame_err, parity_err, busy
    );

    modport slave (
        output rxd,
        input  recv_data, recv_valid, frame_err, parity_err, busy
    );

endinterface

// File: rtl/uart_baud_tick.sv
// uart_baud_tick: one-cycle tick every DIV clocks; restart re-phases the
// counter so the first tick lands exactly DIV clocks after a start edge.
module uart_baud_tick #(
    parameter int DIV = 27
) (
    input  logic clk,
    input  logic rst,
    input  logic restart,
    output logic tick
);
    localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [CW-1:0] LAST = CW'(DIV - 1);

    logic [CW-1:0] cnt;

    assign tick = (cnt == LAST);

    // Free-running divider, wrapped on tick and zeroed on restart.
    always_ff @(posedge clk) begin
        if (rst || restart) cnt <= '0;
        else if (tick)      cnt <= '0;
        else                cnt <= cnt + CW'(1);
    end

endmodule

// File: rtl/uart_receiver.sv
// uart_receiver: 8N1 (or 8E1 with UART_RX_PARITY_EN) deserializer.
// OVERSAMPLE must be even and >= 8; bits are sampled at mid-bit on the
// synchronized line.
module uart_receiver
    import uart_pkg::*;
#(
    parameter int CLK_FREQ   = 50_000_000,
    parameter int BAUD       = 115200,
    parameter int OVERSAMPLE = 16
) (
    input  logic            clk,
    input  logic            rst,
    uart_receiver_if.master rx
);
    localparam int DIV = calc_div(CLK_FREQ, BAUD, OVERSAMPLE);
    localparam int TW  = $clog2(OVERSAMPLE);
    localparam int BW  = $clog2(UART_DATA_W);
    localparam logic [TW-1:0] T_MID    = TW'(OVERSAMPLE / 2 - 1);
    localparam logic [TW-1:0] T_END    = TW'(OVERSAMPLE - 1);
    localparam logic [BW-1:0] BIT_LAST = BW'(UART_DATA_W - 1);

    rx_state_t              state, state_nx;
    logic                   rxd_s1, rxd_s2, rxd_prev;
    logic                   fall, tick, restart, samp, busy;
    logic [TW-1:0]          tcnt;
    logic [BW-1:0]          bitcnt;
    logic [UART_DATA_W-1:0] shreg;
    logic [UART_DATA_W-1:0] recv_data_q;
    logic                   recv_valid_q, frame_err_q;
`ifdef UART_RX_PARITY_EN
    logic                   parity_err_q, par_bad;
`endif

    // Two-flop synchronizer plus previous value; idle-high so reset makes no edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            rxd_s1   <= 1'b1;
            rxd_s2   <= 1'b1;
            rxd_prev <= 1'b1;
        end else begin
            rxd_s1   <= rx.rxd;
            rxd_s2   <= rxd_s1;
            rxd_prev <= rxd_s2;
        end
    end

    assign fall = rxd_prev & ~rxd_s2;

    uart_baud_tick #(.DIV(DIV)) u_tick (
        .clk     (clk),
        .rst     (rst),
        .restart (restart),
        .tick    (tick)
    );

    // State register.
    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nx;
    end

    // Next-state: start edges are taken immediately, everything else on samples.
    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE:   if (fall) state_nx = START;
            START:  if (samp) state_nx = rxd_s2 ? IDLE : DATA;
`ifdef UART_RX_PARITY_EN
            DATA:   if (samp && bitcnt == BIT_LAST) state_nx = PARITY;
            PARITY: if (samp) state_nx = STOP;
`else
            DATA:   if (samp && bitcnt == BIT_LAST) state_nx = STOP;
`endif
            STOP:   if (samp) state_nx = rxd_s2 ? IDLE : BREAK;
            BREAK:  if (rxd_s2) state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // FSM outputs: busy flag, divider re-phase and the mid-bit sample strobe.
    always_comb begin
        busy    = (state != IDLE);
        restart = (state == IDLE) && fall;
        samp    = 1'b0;
        unique case (state)
            START:              samp = tick && (tcnt == T_MID);
            DATA, PARITY, STOP: samp = tick && (tcnt == T_END);
            default:            samp = 1'b0;
        endcase
    end

    // Tick counting, shifting and one-cycle status pulses.
    always_ff @(posedge clk) begin
        if (rst) begin
            tcnt         <= '0;
            bitcnt       <= '0;
            shreg        <= '0;
            recv_data_q  <= '0;
            recv_valid_q <= 1'b0;
            frame_err_q  <= 1'b0;
`ifdef UART_RX_PARITY_EN
            parity_err_q <= 1'b0;
            par_bad      <= 1'b0;
`endif
        end else begin
            recv_valid_q <= 1'b0;
            frame_err_q  <= 1'b0;
`ifdef UART_RX_PARITY_EN
            parity_err_q <= 1'b0;
`endif
            if (state == IDLE || state == BREAK) tcnt <= '0;
            else if (tick)                       tcnt <= samp ? '0 : tcnt + TW'(1);

            if (samp) begin
                unique case (state)
                    START: begin
                        bitcnt <= '0;
`ifdef UART_RX_PARITY_EN
                        par_bad <= 1'b0;
`endif
                    end
                    DATA: begin
                        shreg  <= {rxd_s2, shreg[UART_DATA_W-1:1]};
                        bitcnt <= bitcnt + BW'(1);
                    end
`ifdef UART_RX_PARITY_EN
                    // Even parity: the parity bit equals the XOR of the data bits.
                    PARITY: par_bad <= rxd_s2 ^ (^shreg);
`endif
                    STOP: begin
                        if (!rxd_s2) begin
                            frame_err_q <= 1'b1;
`ifdef UART_RX_PARITY_EN
                        end else if (par_bad) begin
                            parity_err_q <= 1'b1;
`endif
                        end else begin
                            recv_data_q  <= shreg;
                            recv_valid_q <= 1'b1;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    assign rx.recv_data  = recv_data_q;
    assign rx.recv_valid = recv_valid_q;
    assign rx.frame_err  = frame_err_q;
    assign rx.busy       = busy;
`ifdef UART_RX_PARITY_EN
    assign rx.parity_err = parity_err_q;
`else
    assign rx.parity_err = 1'b0;
`endif

endmodule

// File: doc/uart_receiver.md
# uart_receiver

Receive-side counterpart of the button-driven UART sender path on the nvboard test board. Deserializes an asynchronous 8N1 serial line (optional even parity) into bytes. Presents each byte on `recv_data` with a one-cycle `recv_valid` strobe, so a tester can latch it and show it on the seven-segment pair. It sits between the board's RX pin and the display/loopback logic.

## Interface
Parameters:
- `CLK_FREQ`, 50_000_000: system clock in Hz.
- `BAUD`, 115200: line rate in bit/s.
- `OVERSAMPLE`, 16: ticks per bit. Must be an even value ≥ 8.

Ports:
- `clk`  in  1  system clock. One clock only; all logic on its rising edge.
- `rst`  in  1  reset, synchronous, active-high.
- `rxd`  in  1  serial line, idle high, asynchronous to `clk`.
- `recv_data`  out  8  last correctly received byte. Holds its value until the next good frame.
- `recv_valid`  out  1  one-cycle pulse when `recv_data` has been updated.
- `frame_err`  out  1  one-cycle pulse when the stop bit is sampled low.
- `parity_err`  out  1  one-cycle pulse on parity mismatch. Constant 0 when parity is compiled out.
- `busy`  out  1  high in every state except IDLE.

## Operation
- `rxd` passes through a 2-flop synchronizer, then a registered previous value for edge detection.
- Tick generator: `DIV = CLK_FREQ / (BAUD*OVERSAMPLE)`, truncated, minimum 1. It emits `tick` once every DIV cycles. The counter restarts to 0 on the cycle a start edge is detected.
- The FSM advances only on `tick` and counts ticks with `tcnt`.
- IDLE: on a synchronized falling edge, clear `tcnt` and go to START.
- START: at `tcnt == OVERSAMPLE/2 - 1` (mid start bit), sample the line.
  - Low: clear `tcnt`, `bitcnt = 0`, go to DATA.
  - High: treat as a glitch and return to IDLE; no error pulse.
- DATA: every OVERSAMPLE ticks, sample at mid-bit and shift into `shreg`, LSB first. After 8 bits go to PARITY (macro set) or STOP.
- PARITY: sample the bit. Mismatch against even parity of `shreg` sets an internal flag.
- STOP: sample at mid-bit.
  - High, parity OK: `recv_data <= shreg`, pulse `recv_valid`, go to IDLE.
  - High, parity bad: pulse `parity_err`, leave `recv_data` unchanged, go to IDLE.
  - Low: pulse `frame_err`, leave `recv_data` unchanged, go to BREAK.
- BREAK: wait for the synchronized line to be high, then go to IDLE. No start detection happens while in BREAK.
- From IDLE, a new start edge is accepted in the same cycle as a valid pulse. This allows back-to-back frames with zero idle time.

## Timing
- Reset values: `recv_data = 8'h00`, `recv_valid = 0`, `frame_err = 0`, `parity_err = 0`, `busy = 0`. FSM in IDLE, all counters cleared.
- Reset mid-frame aborts the frame immediately with no pulses. The next falling edge after reset is received normally.
- Edge-detect latency: 3 clocks from the `rxd` transition (2 sync stages plus edge register).
- `recv_valid` rises one clock after the stop-bit sample tick. Nominal total is 9.5 bit periods after the start edge (10.5 with parity), plus 3 clocks.
- All status pulses last exactly 1 clock. No more than one of them is asserted per frame.
- Default parameters give DIV = 27 and 432 clocks per bit.

## Configuration
- `UART_RX_PARITY_EN` defined:
  - the frame carries an even parity bit between bit 7 and the stop bit;
  - the PARITY state exists and `parity_err` is live.
- `UART_RX_PARITY_EN` undefined:
  - 8N1 framing;
  - the PARITY state is not compiled;
  - `parity_err` is tied to 0.

## Structure
- Package `uart_pkg`:
  - `rx_state_t` enum: IDLE, START, DATA, PARITY, STOP, BREAK;
  - `UART_DATA_W = 8`;
  - a function computing DIV from CLK_FREQ, BAUD and OVERSAMPLE.
- Sub-module `uart_baud_tick` (inputs `clk`, `rst`, `restart`; output `tick`). The sender can reuse it.
- Synchronizer, FSM, shift register and output registers live in `uart_receiver`.

## Test plan
- Byte 8'h55 sent 8N1 at 115200 with default parameters: `recv_data = 8'h55`, `recv_valid` high exactly 1 clock, about 4107 clocks after the falling edge. No error pulse.
- Frames 8'hA3 and 8'h0F sent back-to-back with no idle gap: two `recv_valid` pulses, 4320 ± DIV clocks apart, data A3 then 0F.
- `rxd` pulled low for 100 clocks, then high: `busy` returns low, with no pulses and `recv_data` unchanged.
- Byte 8'h00 followed by a low stop bit held for 2000 clocks: `frame_err` pulses once and `recv_data` keeps its previous value. The next 8'h3C after the line goes high is received correctly.
- `rst` asserted for 1 clock during data bit 3 of 8'hFF: all outputs return to reset values. A following frame 8'hC6 gives `recv_data = 8'hC6`.
- With `UART_RX_PARITY_EN` defined, send 8'h07 with parity bit 0 (wrong): `parity_err` pulses and there is no `recv_valid`. The same byte with parity bit 1 gives `recv_valid` and `recv_data = 8'h07`.
